// File: rtl/render_pkg.sv
// Shared render types: palette indices, fill opcodes, fill-engine state encoding,
// and a width helper for coordinate counters.
package render_pkg;

  // 4-bit palette indices as scanned out by the renderer.
  localparam logic [3:0] BLACK  = 4'd0;
  localparam logic [3:0] GRAY   = 4'd1;
  localparam logic [3:0] WHITE  = 4'd2;
  localparam logic [3:0] RED    = 4'd3;
  localparam logic [3:0] PINK   = 4'd4;
  localparam logic [3:0] DBROWN = 4'd5;
  localparam logic [3:0] BROWN  = 4'd6;
  localparam logic [3:0] ORANGE = 4'd7;
  localparam logic [3:0] YELLOW = 4'd8;
  localparam logic [3:0] DGREEN = 4'd9;
  localparam logic [3:0] GREEN  = 4'd10;
  localparam logic [3:0] LGREEN = 4'd11;
  localparam logic [3:0] PURPLE = 4'd12;
  localparam logic [3:0] DBLUE  = 4'd13;
  localparam logic [3:0] BLUE   = 4'd14;
  localparam logic [3:0] LBLUE  = 4'd15;

  typedef enum logic {
    FILL_CLEAR = 1'b0,
    FILL_RECT  = 1'b1
  } fill_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fill_clip.sv
// Combinational rectangle clipper.
// Takes signed inclusive corners (x0,y0)-(x1,y1), clamps each to the screen
// and flags rectangles that are inverted or lie entirely off-screen.
//   x0,y0,x1,y1 : signed corners, COORD_W bits
//   cx0..cy1    : clipped corners, screen index widths
//   empty       : nothing to draw
module fill_clip
  import render_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = 1280,
  parameter int unsigned PIXEL_HEIGHT = 720,
  parameter int unsigned COORD_W      = 16,
  parameter int unsigned XW           = idx_width(PIXEL_WIDTH),
  parameter int unsigned YW           = idx_width(PIXEL_HEIGHT)
) (
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [XW-1:0]      cx0,
  output logic [YW-1:0]      cy0,
  output logic [XW-1:0]      cx1,
  output logic [YW-1:0]      cy1,
  output logic               empty
);

  localparam logic signed [COORD_W-1:0] X_MAX = COORD_W'(PIXEL_WIDTH - 1);
  localparam logic signed [COORD_W-1:0] Y_MAX = COORD_W'(PIXEL_HEIGHT - 1);

  logic signed [COORD_W-1:0] sx0, sy0, sx1, sy1;

  assign sx0 = x0;
  assign sy0 = y0;
  assign sx1 = x1;
  assign sy1 = y1;

  // Clamp a signed coordinate into [0, hi]; sign bit means below zero.
  function automatic logic [COORD_W-1:0] clamp(input logic signed [COORD_W-1:0] v,
                                               input logic signed [COORD_W-1:0] hi);
    if (v[COORD_W-1])  return '0;
    else if (v > hi)   return hi;
    else               return v;
  endfunction

  assign cx0 = XW'(clamp(sx0, X_MAX));
  assign cx1 = XW'(clamp(sx1, X_MAX));
  assign cy0 = YW'(clamp(sy0, Y_MAX));
  assign cy1 = YW'(clamp(sy1, Y_MAX));

  // Inverted corners, or the far edge before the screen / near edge past it.
  assign empty = (sx0 > sx1) || (sy0 > sy1) ||
                 sx1[COORD_W-1] || sy1[COORD_W-1] ||
                 (sx0 > X_MAX) || (sy0 > Y_MAX);

endmodule

// File: rtl/frame_fill_writer.sv
// Framebuffer fill engine: accepts CLEAR / clipped RECT commands and emits one
// palette-index write per pixel in raster order on a valid/ready port.
//   clk_in, rst_in (async, active-low)
//   cmd_*          : command handshake and fields (corners signed, inclusive)
//   write_*        : framebuffer write port, addr = x + PIXEL_WIDTH*y
//   busy_out       : engine not idle
//   done_out       : one-cycle pulse at command completion
module frame_fill_writer
  import render_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = 1280,
  parameter int unsigned PIXEL_HEIGHT = 720,
  parameter int unsigned COORD_W      = 16,
  parameter int unsigned ADDR_W       = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               cmd_valid_in,
  output logic               cmd_ready_out,
  input  logic               cmd_op_in,
  input  logic [COORD_W-1:0] cmd_x0_in,
  input  logic [COORD_W-1:0] cmd_y0_in,
  input  logic [COORD_W-1:0] cmd_x1_in,
  input  logic [COORD_W-1:0] cmd_y1_in,
  input  logic [3:0]         cmd_color_in,
  output logic [ADDR_W-1:0]  write_addr_out,
  output logic [3:0]         write_data_out,
  output logic               write_valid_out,
  input  logic               write_ready_in,
  output logic               busy_out,
  output logic               done_out
);

  localparam int unsigned XW = idx_width(PIXEL_WIDTH);
  localparam int unsigned YW = idx_width(PIXEL_HEIGHT);

  fill_state_t state, state_n;

  // Latched command
  fill_op_t           cmd_op;
  logic [COORD_W-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [3:0]         cmd_color;

  // Raster walk
  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     y, y_n;
  logic [ADDR_W-1:0] row_base, row_base_n;

  // Next values of the registered outputs
  logic              cmd_ready_n, write_valid_n, busy_n, done_n;
  logic [ADDR_W-1:0] write_addr_n;
  logic [3:0]        write_data_n;

  logic          accept;
  logic [XW-1:0] clip_cx0, clip_cx1, cx0, cx1;
  logic [YW-1:0] clip_cy0, clip_cy1, cy0, cy1;
  logic          clip_empty, empty;

  assign accept = cmd_valid_in && cmd_ready_out;

  fill_clip #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .PIXEL_HEIGHT (PIXEL_HEIGHT),
    .COORD_W      (COORD_W),
    .XW           (XW),
    .YW           (YW)
  ) u_clip (
    .x0    (cmd_x0),
    .y0    (cmd_y0),
    .x1    (cmd_x1),
    .y1    (cmd_y1),
    .cx0   (clip_cx0),
    .cy0   (clip_cy0),
    .cx1   (clip_cx1),
    .cy1   (clip_cy1),
    .empty (clip_empty)
  );

  // Active bounds: whole screen for CLEAR, clipped corners for RECT.
  // The latched command is stable for the whole operation, so these are too.
  always_comb begin
    cx0   = clip_cx0;
    cx1   = clip_cx1;
    cy0   = clip_cy0;
    cy1   = clip_cy1;
    empty = clip_empty;
    if (cmd_op == FILL_CLEAR) begin
      cx0   = '0;
      cx1   = XW'(PIXEL_WIDTH - 1);
      cy0   = '0;
      cy1   = YW'(PIXEL_HEIGHT - 1);
      empty = 1'b0;
    end
  end

  // Command latch
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cmd_op    <= FILL_CLEAR;
      cmd_x0    <= '0;
      cmd_y0    <= '0;
      cmd_x1    <= '0;
      cmd_y1    <= '0;
      cmd_color <= '0;
    end else if (accept) begin
      cmd_op    <= fill_op_t'(cmd_op_in);
      cmd_x0    <= cmd_x0_in;
      cmd_y0    <= cmd_y0_in;
      cmd_x1    <= cmd_x1_in;
      cmd_y1    <= cmd_y1_in;
      cmd_color <= cmd_color_in;
    end
  end

  // State, walk counters and registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_IDLE;
      x               <= '0;
      y               <= '0;
      row_base        <= '0;
      cmd_ready_out   <= 1'b0;
      write_valid_out <= 1'b0;
      write_addr_out  <= '0;
      write_data_out  <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      state           <= state_n;
      x               <= x_n;
      y               <= y_n;
      row_base        <= row_base_n;
      cmd_ready_out   <= cmd_ready_n;
      write_valid_out <= write_valid_n;
      write_addr_out  <= write_addr_n;
      write_data_out  <= write_data_n;
      busy_out        <= busy_n;
      done_out        <= done_n;
    end
  end

  // Next state and next output values
  always_comb begin
    state_n       = state;
    x_n           = x;
    y_n           = y;
    row_base_n    = row_base;
    cmd_ready_n   = 1'b0;
    write_valid_n = write_valid_out;
    write_addr_n  = write_addr_out;
    write_data_n  = write_data_out;
    done_n        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cmd_ready_n   = 1'b1;
        write_valid_n = 1'b0;
        if (accept) begin
          cmd_ready_n = 1'b0;
          state_n     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (empty) begin
          done_n  = 1'b1;
          state_n = ST_DONE;
        end else begin
          // Single constant multiply; later rows step by PIXEL_WIDTH.
          x_n           = cx0;
          y_n           = cy0;
          row_base_n    = ADDR_W'(PIXEL_WIDTH) * ADDR_W'(cy0);
          write_addr_n  = row_base_n + ADDR_W'(cx0);
          write_data_n  = cmd_color;
          write_valid_n = 1'b1;
          state_n       = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (write_valid_out && write_ready_in) begin
          if ((x == cx1) && (y == cy1)) begin
            write_valid_n = 1'b0;
            done_n        = 1'b1;
            state_n       = ST_DONE;
          end else begin
            if (x < cx1) begin
              x_n = x + XW'(1);
            end else begin
              x_n        = cx0;
              y_n        = y + YW'(1);
              row_base_n = row_base + ADDR_W'(PIXEL_WIDTH);
            end
            write_addr_n = row_base_n + ADDR_W'(x_n);
          end
        end
      end

      ST_DONE: begin
        cmd_ready_n = 1'b1;
        state_n     = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_frame_fill_writer.sv
// Directed bench for frame_fill_writer on an 8x4 framebuffer.
module tb_frame_fill_writer;

  localparam int unsigned PW = 8;
  localparam int unsigned PH = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 5;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          cmd_valid_in = 1'b0;
  logic          cmd_ready_out;
  logic          cmd_op_in = 1'b0;
  logic [CW-1:0] cmd_x0_in = '0, cmd_y0_in = '0, cmd_x1_in = '0, cmd_y1_in = '0;
  logic [3:0]    cmd_color_in = '0;
  logic [AW-1:0] write_addr_out;
  logic [3:0]    write_data_out;
  logic          write_valid_out;
  logic          write_ready_in = 1'b1;
  logic          busy_out;
  logic          done_out;

  int tests_run = 0;
  int tests_failed = 0;

  int got_addr[$];
  int got_data[$];
  int first_valid, done_cyc, done_cnt, busy_cnt, ready_cyc, hold_bad;

  frame_fill_writer #(
    .PIXEL_WIDTH  (PW),
    .PIXEL_HEIGHT (PH),
    .COORD_W      (CW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .cmd_valid_in    (cmd_valid_in),
    .cmd_ready_out   (cmd_ready_out),
    .cmd_op_in       (cmd_op_in),
    .cmd_x0_in       (cmd_x0_in),
    .cmd_y0_in       (cmd_y0_in),
    .cmd_x1_in       (cmd_x1_in),
    .cmd_y1_in       (cmd_y1_in),
    .cmd_color_in    (cmd_color_in),
    .write_addr_out  (write_addr_out),
    .write_data_out  (write_data_out),
    .write_valid_out (write_valid_out),
    .write_ready_in  (write_ready_in),
    .busy_out        (busy_out),
    .done_out        (done_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  // Offer one command for exactly the accept edge; returns at accept+1.
  task automatic send_cmd(input logic op, input int x0, input int y0,
                          input int x1, input int y1, input int color);
    cmd_op_in    = op;
    cmd_x0_in    = CW'(x0);
    cmd_y0_in    = CW'(y0);
    cmd_x1_in    = CW'(x1);
    cmd_y1_in    = CW'(y1);
    cmd_color_in = 4'(color);
    cmd_valid_in = 1'b1;
    tick();
    cmd_valid_in = 1'b0;
  endtask

  // Observe one command from accept+1 until cmd_ready_out returns (bounded).
  // pat gives write_ready_in per offered-write cycle, LSB first.
  task automatic collect(input logic [31:0] pat, input int max_cyc);
    int vidx = 0;
    logic rdy;
    logic prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [3:0] prev_data = '0;
    got_addr.delete();
    got_data.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    ready_cyc = -1; hold_bad = 0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      if (write_valid_out) begin
        rdy  = pat[vidx];
        vidx = (vidx + 1) % 32;
      end else begin
        rdy = 1'b1;
      end
      write_ready_in = rdy;
      if (prev_stall && (write_valid_out !== 1'b1 || write_addr_out !== prev_addr ||
                         write_data_out !== prev_data))
        hold_bad++;
      prev_stall = write_valid_out && !rdy;
      prev_addr  = write_addr_out;
      prev_data  = write_data_out;
      if (write_valid_out && first_valid < 0) first_valid = cyc;
      if (write_valid_out && rdy) begin
        got_addr.push_back(int'(write_addr_out));
        got_data.push_back(int'(write_data_out));
      end
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_out) busy_cnt++;
      if (cmd_ready_out) begin
        ready_cyc = cyc;
        break;
      end
      tick();
    end
    write_ready_in = 1'b1;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    #12;
    tests_run++;
    if ({cmd_ready_out, write_valid_out, busy_out, done_out} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got rdy/val/busy/done=%b expected 0000",
               {cmd_ready_out, write_valid_out, busy_out, done_out});
    end
    tests_run++;
    if (write_addr_out !== '0 || write_data_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%0d data=%0d expected 0/0", write_addr_out, write_data_out);
    end
    tick();
    rst_in = 1'b1;
    #1;
    tests_run++;
    if (cmd_ready_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_before_edge: got %b expected 0", cmd_ready_out);
    end
    tick();
    tests_run++;
    if (cmd_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_after_edge: got %b expected 1", cmd_ready_out);
    end
  endtask

  task automatic test_clear;
    send_cmd(1'b0, 0, 0, 0, 0, 2);
    collect('1, 100);
    tests_run++;
    if (got_addr.size() != 32) begin
      tests_failed++;
      $display("FAIL clear_count: got %0d writes expected 32", got_addr.size());
    end
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if (i >= got_addr.size() || got_addr[i] !== i || got_data[i] !== 2) begin
        tests_failed++;
        $display("FAIL clear_pixel[%0d]: got addr=%0d data=%0d expected addr=%0d data=2", i,
                 (i < got_addr.size()) ? got_addr[i] : -1,
                 (i < got_data.size()) ? got_data[i] : -1, i);
      end
    end
    tests_run++;
    if (first_valid != 2 || done_cyc != 34 || ready_cyc != 35 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL clear_timing: got valid@%0d done@%0d x%0d ready@%0d expected 2/34 x1/35",
               first_valid, done_cyc, done_cnt, ready_cyc);
    end
  endtask

  task automatic test_rect;
    int exp_a[$] = '{10, 11, 12, 18, 19, 20};
    send_cmd(1'b1, 2, 1, 4, 2, 3);
    collect('1, 100);
    tests_run++;
    if (got_addr.size() != exp_a.size()) begin
      tests_failed++;
      $display("FAIL rect_count: got %0d writes expected %0d", got_addr.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      tests_run++;
      if (i >= got_addr.size() || got_addr[i] !== exp_a[i] || got_data[i] !== 3) begin
        tests_failed++;
        $display("FAIL rect_pixel[%0d]: got addr=%0d data=%0d expected addr=%0d data=3", i,
                 (i < got_addr.size()) ? got_addr[i] : -1,
                 (i < got_data.size()) ? got_data[i] : -1, exp_a[i]);
      end
    end
    tests_run++;
    if (done_cnt != 1 || ready_cyc < 0) begin
      tests_failed++;
      $display("FAIL rect_done: got %0d pulses ready@%0d expected 1 pulse", done_cnt, ready_cyc);
    end
  endtask

  task automatic test_clip;
    send_cmd(1'b1, -3, -2, 1, 0, 5);
    collect('1, 100);
    tests_run++;
    if (got_addr.size() != 2 || got_addr[0] !== 0 || got_addr[1] !== 1 ||
        got_data[0] !== 5 || got_data[1] !== 5) begin
      tests_failed++;
      $display("FAIL clip_neg: got %0d writes first=%0d expected addrs 0,1 data 5",
               got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : -1);
    end
    send_cmd(1'b1, 9, 0, 12, 3, 4);
    collect('1, 100);
    tests_run++;
    if (got_addr.size() != 0 || done_cyc != 2 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL clip_offscreen: got %0d writes done@%0d x%0d expected 0 writes done@2 x1",
               got_addr.size(), done_cyc, done_cnt);
    end
  endtask

  task automatic test_inverted;
    send_cmd(1'b1, 5, 2, 3, 1, 6);
    collect('1, 100);
    tests_run++;
    if (got_addr.size() != 0 || done_cnt != 1 || busy_cnt != 2) begin
      tests_failed++;
      $display("FAIL inverted: got %0d writes %0d done %0d busy cycles expected 0/1/2",
               got_addr.size(), done_cnt, busy_cnt);
    end
  endtask

  task automatic test_backpressure;
    // ready pattern 1,0,0,1,0,1,1 (LSB first), then held high
    send_cmd(1'b1, 0, 0, 3, 0, 7);
    collect(32'hFFFF_FFE9, 100);
    tests_run++;
    if (got_addr.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d writes expected 4", got_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (i >= got_addr.size() || got_addr[i] !== i || got_data[i] !== 7) begin
        tests_failed++;
        $display("FAIL bp_pixel[%0d]: got addr=%0d expected addr=%0d data=7", i,
                 (i < got_addr.size()) ? got_addr[i] : -1, i);
      end
    end
    tests_run++;
    if (hold_bad != 0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL bp_hold: got %0d unstable stall cycles, %0d done expected 0/1",
               hold_bad, done_cnt);
    end
  endtask

  task automatic test_reset_midop;
    logic saw_done = 1'b0;
    write_ready_in = 1'b1;
    send_cmd(1'b0, 0, 0, 0, 0, 9);
    // accept+1 -> accept+6 is the 5th write (addr 4)
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (write_valid_out !== 1'b1 || write_addr_out !== AW'(4)) begin
      tests_failed++;
      $display("FAIL midop_fifth: got valid=%b addr=%0d expected 1/4", write_valid_out, write_addr_out);
    end
    #2;
    rst_in = 1'b0;
    #1;
    tests_run++;
    if (write_valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_async: got valid=%b busy=%b done=%b expected 000",
               write_valid_out, busy_out, done_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_out || write_valid_out) saw_done = 1'b1;
    end
    rst_in = 1'b1;
    tick();
    if (done_out) saw_done = 1'b1;
    tests_run++;
    if (saw_done !== 1'b0 || cmd_ready_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_recover: got stray done/valid=%b ready=%b expected 0/1",
               saw_done, cmd_ready_out);
    end
    send_cmd(1'b1, 0, 0, 0, 0, 1);
    collect('1, 100);
    tests_run++;
    if (got_addr.size() != 1 || got_addr[0] !== 0 || got_data[0] !== 1 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL midop_1x1: got %0d writes addr=%0d done=%0d expected 1 write addr 0 done 1",
               got_addr.size(), (got_addr.size() > 0) ? got_addr[0] : -1, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_rect();
    test_clip();
    test_inverted();
    test_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
